io_input_conditioner: RTL and testbench
=======================================

Name: io_input_conditioner

Overview:
- Conditions raw DE1-SoC board inputs (SW[9:0], KEY[3:0]) into a clean 14-bit io_input_bus for the data-memory IO window.
- Sits directly upstream of the data memory's memory-mapped input words (base+7 = SW, base+8 = KEY).
- Per bit: 2-flop synchroniser, then a counter-based debouncer.
- KEY inputs are inverted so software reads pressed = 1.

Parameters:
- NUM_SW, 10, number of slide-switch inputs.
- NUM_KEY, 4, number of push-button inputs (raw active-low).
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised cycles required before the output follows (10 ms at 50 MHz). Minimum 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; not overridden).

Ports:
- clock, input, 1, system clock; all state on rising edge.
- reset_n, input, 1, asynchronous active-low reset. Assertion clears state immediately; deassertion is synchronous to clock upstream.
- sw_raw, input, NUM_SW, asynchronous switch levels; 1 = up.
- key_raw_n, input, NUM_KEY, asynchronous button levels; 0 = pressed.
- io_input_bus, output, NUM_SW+NUM_KEY, conditioned bus: [NUM_SW-1:0] = SW, [NUM_SW+NUM_KEY-1:NUM_SW] = KEY pressed (active-high).

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - Synchroniser flops go to idle levels: SW = 0, KEY raw = 1 (released).
  - All debounce counters = 0.
  - All stable bits = 0 (KEY stable in pressed-polarity).
  - io_input_bus = 0 while in reset and on the first cycle after release.
  - No spurious press after reset, because the KEY sync idle level matches released.
- Synchroniser: sync1 <= raw; sync2 <= sync1, per bit. KEY bits are inverted after sync2: key_p = ~sync2.
- Debouncer, per bit, one counter and one stable register, every edge:
  - sync value == stable: counter <= 0.
  - sync value != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync value != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync value; counter <= 0.
- Latency: a raw change set up before edge 0 and held appears on io_input_bus after edge DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES+2 edges total). With DEBOUNCE_CYCLES = 1 the latency is 3 edges.
- Glitch rejection:
  - Any return to the stable value before the count completes resets the counter.
  - Pulses shorter than DEBOUNCE_CYCLES synchronised cycles never reach the output.
- Bit independence: each bit has its own counter. Simultaneous changes on multiple bits resolve independently and may update on the same edge.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
- io_input_bus is registered (driven directly from the stable registers); no combinational path from raw inputs.
- Reset mid-count: pending changes are discarded; the bit restarts from its reset state.

Optional Feature:
- Macro: IO_KEY_TOGGLE_EN.
- Defined:
  - Each KEY output bit is a toggle flop, flipped on every debounced press edge (stable rising 0 -> 1). Release has no effect.
  - Toggle flops reset to 0.
  - Latency to toggle = same as debounce latency.
- Undefined: KEY output bits equal the debounced pressed level.
- SW path is identical in both builds.

Decomposition:
- Shared package io_pkg:
  - IO_NUM_SW = 10, IO_NUM_KEY = 4, IO_INPUT_BUS_LEN = 14.
  - IO_BASE_ADDR = 64, IO_SW_OFFSET = 7, IO_KEY_OFFSET = 8.
  - Default DEBOUNCE_CYCLES.
- One natural sub-module: io_debounce_bit.
  - Contains the 2-flop sync, counter, stable reg and idle-level parameter.
  - Instantiated per bit with a generate loop.
- Top level handles inversion, toggle option and bus packing.

Test Plan:
- Reset value: reset_n = 0 with sw_raw = 10'h3FF, key_raw_n = 4'h0 -> io_input_bus = 14'h0000. After release with inputs held (DEBOUNCE_CYCLES = 4): io_input_bus = 14'h3FFF at edge 5 after release, not earlier.
- Latency: DEBOUNCE_CYCLES = 4, sw_raw[3] 0 -> 1 held -> io_input_bus[3] rises exactly after the 6th rising edge; all other bits stay 0.
- Glitch: DEBOUNCE_CYCLES = 4, key_raw_n[1] low for 3 cycles then high -> io_input_bus[11] stays 0. Low for 4+ cycles -> io_input_bus[11] = 1.
- Bounce: sw_raw[0] toggles every cycle for 20 cycles, then holds 1 -> output stays 0 during bounce and rises 6 edges after the final hold begins.
- Async reset mid-count: start a sw_raw[9] change, assert reset_n between edges at count 2 -> io_input_bus clears immediately without waiting for a clock edge. After release the full latency is re-observed.
- IO_KEY_TOGGLE_EN: three debounced presses of KEY0 (key_raw_n[0] low 10 cycles, high 10 cycles, repeated) -> io_input_bus[10] goes 1, 0, 1 on each press only.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants for the DE1-SoC input window of data memory.
// Bus layout: SW in the low bits, KEY pressed flags above them.
package io_pkg;

  localparam int IO_NUM_SW          = 10;
  localparam int IO_NUM_KEY         = 4;
  localparam int IO_INPUT_BUS_LEN   = IO_NUM_SW + IO_NUM_KEY;
  localparam int IO_BASE_ADDR       = 64;
  localparam int IO_SW_OFFSET       = 7;
  localparam int IO_KEY_OFFSET      = 8;
  localparam int IO_DEBOUNCE_CYCLES = 500000;

  typedef struct packed {
    logic [IO_NUM_KEY-1:0] key;
    logic [IO_NUM_SW-1:0]  sw;
  } io_bus_t;

  function automatic int io_word_addr(input int offset);
    return IO_BASE_ADDR + offset;
  endfunction

endpackage

// File: rtl/io_debounce_bit.sv
// One input bit: 2-flop synchroniser followed by a counter debouncer.
// rise pulses on the edge where the stable level goes 0 -> 1.
module io_debounce_bit
  import io_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES,
  parameter int   CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter logic IDLE            = 1'b0,
  parameter logic INVERT          = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             sval;
  logic             hit;
  logic [CNT_W-1:0] cnt;

  assign sval = sync2 ^ INVERT;
  assign hit  = (sval != stable) && (cnt == CNT_MAX);
  assign rise = hit & sval;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= IDLE;
      sync2  <= IDLE;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sval == stable) begin
        cnt <= '0;
      end else if (hit) begin
        stable <= sval;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions SW/KEY board inputs into the registered io_input_bus.
// Build option IO_KEY_TOGGLE_EN: KEY bits become press-toggled flops.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int NUM_SW          = IO_NUM_SW,
  parameter int NUM_KEY         = IO_NUM_KEY,
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_CYCLES
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_SW-1:0]         sw_raw,
  input  logic [NUM_KEY-1:0]        key_raw_n,
  output logic [NUM_SW+NUM_KEY-1:0] io_input_bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_SW-1:0]  sw_stable;
  logic [NUM_SW-1:0]  sw_rise;
  logic [NUM_KEY-1:0] key_stable;
  logic [NUM_KEY-1:0] key_rise;
  logic [NUM_KEY-1:0] key_out;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    io_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .IDLE            (1'b0),
      .INVERT          (1'b0)
    ) u_db (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (sw_raw[i]),
      .stable  (sw_stable[i]),
      .rise    (sw_rise[i])
    );
  end

  // Keys idle released (raw 1) so reset never looks like a press.
  for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
    io_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .IDLE            (1'b1),
      .INVERT          (1'b1)
    ) u_db (
      .clock   (clock),
      .reset_n (reset_n),
      .raw     (key_raw_n[i]),
      .stable  (key_stable[i]),
      .rise    (key_rise[i])
    );
  end

`ifdef IO_KEY_TOGGLE_EN
  logic [NUM_KEY-1:0] key_tog;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_tog <= '0;
    end else begin
      key_tog <= key_tog ^ key_rise;
    end
  end

  assign key_out = key_tog;

  logic unused_rise;
  assign unused_rise = ^{sw_rise, key_stable};
`else
  assign key_out = key_stable;

  logic unused_rise;
  assign unused_rise = ^{sw_rise, key_rise};
`endif

  assign io_input_bus = {key_out, sw_stable};

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYCLES = 4.
// Works in both default and IO_KEY_TOGGLE_EN builds.
module tb_io_input_conditioner;

`ifdef IO_KEY_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic [9:0]  sw_raw;
  logic [3:0]  key_raw_n;
  logic [13:0] io_input_bus;

  int n_tests;
  int n_fail;

  io_input_conditioner #(
    .NUM_SW          (10),
    .NUM_KEY         (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sw_raw       (sw_raw),
    .key_raw_n    (key_raw_n),
    .io_input_bus (io_input_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(
    input string       tag,
    input logic [13:0] got,
    input logic [13:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic [13:0] base;
  logic        tog;
  logic        kexp;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    sw_raw    = 10'h3FF;
    key_raw_n = 4'h0;

    // reset value and release latency
    tick(3);
    check("rst_hold", io_input_bus, 14'h0000);
    reset_n = 1'b1;
    tick(1);
    check("rst_first", io_input_bus, 14'h0000);
    tick(4);
    check("rst_e5", io_input_bus, 14'h0000);
    tick(1);
    check("rst_e6", io_input_bus, 14'h3FFF);

    reset_n = 1'b0;
    #1;
    check("rst_async", io_input_bus, 14'h0000);
    sw_raw    = 10'h000;
    key_raw_n = 4'hF;
    tick(2);
    reset_n = 1'b1;
    tick(10);
    check("idle", io_input_bus, 14'h0000);

    // latency of a single switch
    sw_raw[3] = 1'b1;
    tick(5);
    check("lat_e5", io_input_bus, 14'h0000);
    tick(1);
    check("lat_e6", io_input_bus, 14'h0008);

    // short key glitch is rejected
    key_raw_n[1] = 1'b0;
    tick(3);
    key_raw_n[1] = 1'b1;
    tick(10);
    check("glitch3", io_input_bus, 14'h0008);

    // 4-cycle press is accepted
    key_raw_n[1] = 1'b0;
    tick(4);
    key_raw_n[1] = 1'b1;
    tick(1);
    check("press4_e5", io_input_bus, 14'h0008);
    tick(1);
    check("press4_e6", io_input_bus, 14'h0808);
    tick(10);
    base = TOG ? 14'h0808 : 14'h0008;
    check("press4_rel", io_input_bus, base);

    // bounce on sw[0]
    for (int i = 0; i < 20; i++) begin
      sw_raw[0] = ~sw_raw[0];
      tick(1);
      check("bounce", io_input_bus, base);
    end
    sw_raw[0] = 1'b1;
    tick(5);
    check("bounce_e5", io_input_bus, base);
    tick(1);
    check("bounce_e6", io_input_bus, base | 14'h0001);

    // async reset mid-count on sw[9]
    sw_raw[9] = 1'b1;
    tick(4);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst", io_input_bus, 14'h0000);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    check("mid_e5", io_input_bus, 14'h0000);
    tick(1);
    check("mid_e6", io_input_bus, 14'h0209);

    // three presses of KEY0
    tog = 1'b0;
    for (int p = 0; p < 3; p++) begin
      key_raw_n[0] = 1'b0;
      tick(5);
      kexp = TOG ? tog : 1'b0;
      check("k0_pre", {13'b0, io_input_bus[10]}, {13'b0, kexp});
      tog = ~tog;
      tick(1);
      kexp = TOG ? tog : 1'b1;
      check("k0_press", {13'b0, io_input_bus[10]}, {13'b0, kexp});
      tick(4);
      key_raw_n[0] = 1'b1;
      tick(10);
      kexp = TOG ? tog : 1'b0;
      check("k0_rel", {13'b0, io_input_bus[10]}, {13'b0, kexp});
      check("sw_keep", {4'b0, io_input_bus[9:0]}, 14'h0209);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
